// File: rtl/sort_ctrl.sv
// Sample collector and result handshake for a median sort datapath.
// Gathers NUM_VALS samples into a packed frame and waits SORT_LAT+1 cycles
// for the median, then holds it until downstream accepts.
module sort_ctrl #(
   parameter  int NUM_VALS = 9,
   parameter  int SIZE     = 8,
   parameter  int SORT_LAT = 1,
   localparam int CNT_W    = $clog2(NUM_VALS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   input  logic [SIZE-1:0]          s_data,
   output logic                     s_ready,
   output logic [NUM_VALS*SIZE-1:0] sort_in,
   input  logic [SIZE-1:0]          sort_median,
   output logic                     m_valid,
   output logic [SIZE-1:0]          m_median,
   input  logic                     m_ready,
   output logic [CNT_W-1:0]         count,
   output logic [15:0]              frames_done
);

   localparam int WC_W = (SORT_LAT > 0) ? $clog2(SORT_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VALS - 1);
   localparam logic [WC_W-1:0]  WAIT_LD  = WC_W'(SORT_LAT);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic            accept;
   logic            last_accept;
   logic            capture;
   logic            handshake;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      s_ready     = 1'b0;
      accept      = 1'b0;
      last_accept = 1'b0;
      capture     = 1'b0;
      handshake   = 1'b0;
      case (state)
         FILL: begin
            s_ready = rst_n;
            if (s_valid) begin
               accept = 1'b1;
               if (count == LAST_IDX) begin
                  last_accept = 1'b1;
                  state_nxt   = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               handshake = 1'b1;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // Frame capture: slot 0 (first sample) lands in the most-significant bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sort_in <= '0;
         count   <= '0;
      end else begin
         for (int i = 0; i < NUM_VALS; i++) begin
            if (accept && (count == CNT_W'(i))) begin
               sort_in[(NUM_VALS-1-i)*SIZE +: SIZE] <= s_data;
            end
         end
         if (accept) begin
            count <= count + 1'b1;
         end else if (handshake) begin
            count <= '0;
         end
      end
   end

   // WAIT length is SORT_LAT+1 cycles: loaded with SORT_LAT, captures at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (last_accept) begin
         wait_cnt <= WAIT_LD;
      end else if (state == WAIT && wait_cnt != '0) begin
         wait_cnt <= wait_cnt - 1'b1;
      end
   end

   // Result register and frame counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_median    <= '0;
         m_valid     <= 1'b0;
         frames_done <= '0;
      end else begin
         if (capture) begin
            m_median <= sort_median;
            m_valid  <= 1'b1;
         end else if (handshake) begin
            m_valid <= 1'b0;
         end
         if (handshake) begin
            frames_done <= frames_done + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_sort_ctrl.sv
// Randomized and directed bench for sort_ctrl with a behavioural one-stage
// median datapath; results are checked by a scoreboard-driven monitor.
module tb_sort_ctrl;

   localparam int NV  = 9;
   localparam int SZ  = 8;
   localparam int LAT = 1;
   localparam int CW  = $clog2(NV + 1);

   logic             clk     = 1'b0;
   logic             rst_n   = 1'b0;
   logic             s_valid = 1'b0;
   logic [SZ-1:0]    s_data  = '0;
   logic             m_ready = 1'b0;
   logic             s_ready;
   logic [NV*SZ-1:0] sort_in;
   logic [SZ-1:0]    sort_median;
   logic             m_valid;
   logic [SZ-1:0]    m_median;
   logic [CW-1:0]    count;
   logic [15:0]      frames_done;

   always #5 clk = ~clk;

   sort_ctrl #(.NUM_VALS(NV), .SIZE(SZ), .SORT_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .sort_in     (sort_in),
      .sort_median (sort_median),
      .m_valid     (m_valid),
      .m_median    (m_median),
      .m_ready     (m_ready),
      .count       (count),
      .frames_done (frames_done)
   );

   // Stand-in sort datapath: one register stage after a full sort
   function automatic logic [SZ-1:0] dp_median(input logic [NV*SZ-1:0] f);
      logic [SZ-1:0] a[NV];
      logic [SZ-1:0] t;
      for (int i = 0; i < NV; i++) a[i] = f[i*SZ +: SZ];
      for (int i = 0; i < NV; i++)
         for (int j = 0; j < NV-1-i; j++)
            if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
      return a[NV/2];
   endfunction

   always @(posedge clk) sort_median <= dp_median(sort_in);

   typedef struct {
      logic [SZ-1:0]    med;
      logic [NV*SZ-1:0] frame;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   frame_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   hs_cyc = -1;
   int   first_acc_cyc = -1;
   int   nfr = 0;
   int   rmode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // m_ready driver: 0 = always ready, 1 = stalled, 2 = random
   always @(posedge clk) begin
      #1;
      case (rmode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'b0;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: compares each new result against the scoreboard and tracks hold/handshake
   logic [SZ-1:0]    held_med;
   logic [NV*SZ-1:0] held_frame;
   logic             prev_v  = 1'b0;
   logic             prev_hs = 1'b0;
   int               fd_exp  = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         fd_exp  = 0;
         prev_v  = 1'b0;
         prev_hs = 1'b0;
         chk("rst_s_ready", 128'(s_ready), 128'(0));
         chk("rst_m_valid", 128'(m_valid), 128'(0));
         chk("rst_count", 128'(count), 128'(0));
         chk("rst_frames_done", 128'(frames_done), 128'(0));
      end else begin
         if (prev_hs) begin
            chk("hs_m_valid_clear", 128'(m_valid), 128'(0));
            chk("hs_count_clear", 128'(count), 128'(0));
            chk("hs_s_ready", 128'(s_ready), 128'(1));
            chk("hs_frames_done", 128'(frames_done), 128'(fd_exp));
         end
         if (m_valid && !prev_v) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 128'(m_valid), 128'(0));
            end else begin
               e = sb.pop_front();
               chk("median", 128'(m_median), 128'(e.med));
               chk("sort_in_frame", 128'(sort_in), 128'(e.frame));
               chk("latency", 128'(cyc), 128'(e.cyc));
               held_med   = e.med;
               held_frame = e.frame;
            end
         end else if (m_valid && prev_v) begin
            chk("hold_median", 128'(m_median), 128'(held_med));
            chk("hold_sort_in", 128'(sort_in), 128'(held_frame));
            chk("out_s_ready", 128'(s_ready), 128'(0));
         end
         prev_v  = m_valid;
         prev_hs = m_valid && m_ready;
         if (prev_hs) begin
            fd_exp = (fd_exp + 1) & 16'hFFFF;
            hs_cyc = cyc + 1;
         end
      end
   end

   task automatic send(input logic [SZ-1:0] d, input int gap);
      logic acc;
      int   tries;
      exp_t e;
      int   s[$];
      for (int g = 0; g < gap; g++) begin
         s_valid = 1'b0;
         s_data  = 8'($urandom);
         @(posedge clk); #1;
         if (frame_q.size() > 0) chk("idle_count", 128'(count), 128'(frame_q.size()));
      end
      s_valid = 1'b1;
      s_data  = d;
      tries   = 0;
      do begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk); #1;
         tries++;
      end while (!acc && tries < 300);
      s_valid = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 128'(0), 128'(1));
         return;
      end
      frame_q.push_back(int'(d));
      chk("accept_count", 128'(count), 128'(frame_q.size()));
      if (frame_q.size() == 1) first_acc_cyc = cyc;
      if (frame_q.size() == NV) begin
         s = frame_q;
         s.sort();
         e.med   = 8'(s[NV/2]);
         e.frame = '0;
         for (int i = 0; i < NV; i++) e.frame[(NV-1-i)*SZ +: SZ] = 8'(frame_q[i]);
         e.cyc   = cyc + LAT + 1;
         sb.push_back(e);
         frame_q.delete();
         nfr++;
      end
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sb.size() == 0 && !m_valid) && n < 500);
      if (n >= 500) chk("drain_timeout", 128'(sb.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset for three cycles, then release
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("s_ready_after_reset", 128'(s_ready), 128'(1));
      @(posedge clk); #1;

      // Descending frame with downstream always ready
      rmode = 0;
      for (int i = 9; i >= 1; i--) send(8'(i), 0);
      drain();
      chk("frames_after_first", 128'(frames_done), 128'(nfr));

      // Same frame with backpressure; offered 77s must be ignored
      rmode = 1;
      for (int i = 9; i >= 1; i--) send(8'(i), 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!m_valid && n < 50);
      chk("bp_m_valid_seen", 128'(m_valid), 128'(1));
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = 8'd77;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_m_valid", 128'(m_valid), 128'(1));
         chk("bp_m_median", 128'(m_median), 128'(5));
         chk("bp_s_ready", 128'(s_ready), 128'(0));
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      rmode   = 0;
      drain();
      @(negedge clk);
      chk("bp_count_after", 128'(count), 128'(0));
      chk("bp_s_ready_after", 128'(s_ready), 128'(1));
      @(posedge clk); #1;

      // Identical samples with idle cycles between accepts
      for (int i = 0; i < NV; i++) send(8'd200, 1);
      drain();

      // Abort a partial frame with a reset pulse
      for (int i = 0; i < 4; i++) send(8'($urandom), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_count", 128'(count), 128'(0));
      chk("abort_sort_in", 128'(sort_in), 128'(0));
      frame_q.delete();
      nfr = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < NV; i++) send((i % 2) ? 8'd255 : 8'd0, 0);
      drain();

      // Two frames back-to-back; second frame starts the edge after the handshake
      for (int i = 0; i < NV; i++) send(8'($urandom), 0);
      send(8'($urandom), 0);
      chk("b2b_first_accept", 128'(first_acc_cyc), 128'(hs_cyc + 1));
      for (int i = 1; i < NV; i++) send(8'($urandom), 0);
      drain();
      chk("b2b_frames_done", 128'(frames_done), 128'(nfr));

      // Randomized frames, gaps and backpressure
      rmode = 2;
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < NV; i++) begin
            if (f % 4 == 0) send(8'($urandom_range(0, 3)), $urandom_range(0, 2));
            else            send(8'($urandom), $urandom_range(0, 2));
         end
      end
      rmode = 0;
      drain();
      chk("final_frames_done", 128'(frames_done), 128'(nfr));
      chk("scoreboard_empty", 128'(sb.size()), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
